// File: rtl/seg_pkg.sv
// Shared types and constants for the segment-pattern reader.
// Holds the FSM state type, the 16-entry segment pattern table, the
// invalid-pattern marker and the table decode helper.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_REPORT
   } state_e;

   localparam int unsigned CNT_W = 8;

   // last_pat reset value; differs from the post-reset synchronizer value,
   // so the first settled pattern is always reported
   localparam logic [6:0] INVALID_PAT = 7'h7F;

   // Segment-driver output for each {D,N1,N2,N3} code, index 0 first
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1111111, 7'b0011010, 7'b0101100, 7'b0110110,
      7'b1000111, 7'b1010011, 7'b1100101, 7'b1001010,
      7'b1111111, 7'b0111001, 7'b1011100, 7'b1101001,
      7'b1110010, 7'b0010111, 7'b0100111, 7'b1100011
   };

   typedef struct packed {
      logic       err;
      logic [3:0] code;
   } decode_t;

   // Lowest matching index wins; no match gives err=1 and code 0
   function automatic decode_t seg_decode(input logic [6:0] pat);
      decode_t r;
      logic    hit;
      r.err  = 1'b1;
      r.code = '0;
      hit    = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (!hit && (pat == SEG_TABLE[i])) begin
            hit    = 1'b1;
            r.err  = 1'b0;
            r.code = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_stable.sv
// Two-flop synchronizer for the segment inputs plus a saturating
// stability counter on the synchronized value.
module seg_stable
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       seg_i,
   output logic [6:0]       seg_s_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             chg_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]       sync1_q;
   logic [6:0]       seg_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             chg_q, chg_d;

   // The first stage already holds the next seg_s, so comparing it with
   // seg_s lets the count restart on the same edge seg_s takes a new value.
   always_comb begin
      chg_d = (sync1_q != seg_s_q);
      cnt_d = cnt_q;
      if (chg_d)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   // Synchronizer stages, stability counter and change flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         seg_s_q <= '0;
         cnt_q   <= '0;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= seg_i;
         seg_s_q <= sync1_q;
         cnt_q   <= cnt_d;
         chg_q   <= chg_d;
      end
   end

   assign seg_s_o = seg_s_q;
   assign cnt_o   = cnt_q;
   assign chg_o   = chg_q;

endmodule

// File: rtl/seg_reader.sv
// Seven-segment pattern reader: waits for a stable pattern, decodes it
// through the shared table and holds the result until acknowledged.
// Optional error counter output enabled by defining SEG_READER_ERRCNT_EN.
module seg_reader
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg,
   input  logic       ack,
   output logic       out_valid,
   output logic       D,
   output logic       N1,
   output logic       N2,
   output logic       N3,
   output logic       err,
   output logic       overrun
`ifdef SEG_READER_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]       seg_s;
   logic [CNT_W-1:0] cnt;
   logic             chg;
   logic             stable, qualify;
   decode_t          dec;

   state_e     state_q, state_d;
   logic [6:0] last_pat_q, last_pat_d;
   logic [3:0] code_q, code_d;
   logic       err_q, err_d;
   logic       ovr_q, ovr_d;
   logic       qual_q;

   seg_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_stable (
      .clk     (clk),
      .rst     (rst),
      .seg_i   (seg),
      .seg_s_o (seg_s),
      .cnt_o   (cnt),
      .chg_o   (chg)
   );

   assign stable  = (cnt == CNT_MAX);
   assign qualify = stable && (seg_s != last_pat_q);
   assign dec     = seg_decode(seg_s);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (chg) state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (qualify)     state_d = ST_REPORT;
            else if (stable) state_d = ST_IDLE;
         end
         // Leaving via SETTLE whenever seg_s differs from last_pat keeps a
         // pattern that arrived while pending (qualified or still settling)
         ST_REPORT: if (ack) state_d = (seg_s != last_pat_q) ? ST_SETTLE : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Result capture and overrun detection
   always_comb begin
      code_d     = code_q;
      err_d      = err_q;
      last_pat_d = last_pat_q;
      if ((state_q == ST_SETTLE) && qualify) begin
         code_d     = dec.code;
         err_d      = dec.err;
         last_pat_d = seg_s;
      end
      // qualify stays high while a result is pending; flag only its rising edge
      ovr_d = (state_q == ST_REPORT) && qualify && !ack && !qual_q;
   end

   // Result, last-pattern and overrun registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q     <= '0;
         err_q      <= 1'b0;
         last_pat_q <= INVALID_PAT;
         ovr_q      <= 1'b0;
         qual_q     <= 1'b0;
      end else begin
         code_q     <= code_d;
         err_q      <= err_d;
         last_pat_q <= last_pat_d;
         ovr_q      <= ovr_d;
         qual_q     <= qualify;
      end
   end

   assign out_valid       = (state_q == ST_REPORT);
   assign {D, N1, N2, N3} = code_q;
   assign err             = err_q;
   assign overrun         = ovr_q;

`ifdef SEG_READER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Count reports of unknown patterns, saturating
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == ST_SETTLE) && qualify && dec.err && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_reader.sv
// Directed self-checking bench for seg_reader with STABLE_CYCLES=4.
module tb_seg_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic       ack;
   logic       out_valid, D, N1, N2, N3, err, overrun;
   logic [3:0] code;
`ifdef SEG_READER_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   localparam logic [6:0] P_0001 = 7'b0011010;
   localparam logic [6:0] P_ALL  = 7'b1111111;
   localparam logic [6:0] P_1001 = 7'b0111001;
   localparam logic [6:0] P_0111 = 7'b1001010;
   localparam logic [6:0] P_BAD  = 7'b0000001;

   always #5 clk = ~clk;

   seg_reader #(.STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .ack       (ack),
      .out_valid (out_valid),
      .D         (D),
      .N1        (N1),
      .N2        (N2),
      .N3        (N3),
      .err       (err),
      .overrun   (overrun)
`ifdef SEG_READER_ERRCNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   assign code = {D, N1, N2, N3};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Apply a pattern, expect it reported 6 edges later, then acknowledge
   task automatic report(input logic [6:0] pat, input logic [3:0] exp_code,
                         input logic exp_err, input string tag);
      int unsigned n;
      seg = pat;
      n = 0;
      while (n < 20 && !out_valid) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, 6);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_code"}, code, exp_code);
      check({tag, "_err"}, err, exp_err);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_acked"}, out_valid, 0);
   endtask

   initial begin
      int unsigned n;
      int unsigned pulses;
      logic        saw;

      rst = 1'b1;
      seg = '0;
      ack = 1'b0;
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_code", code, 0);
      check("rst_err", err, 0);
      check("rst_ovr", overrun, 0);

      // Release reset with a pattern held: valid on edge 6 exactly
      seg = P_0001;
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("rel_edge%0d", i), out_valid, (i == 6));
      end
      check("rel_code", code, 4'b0001);
      check("rel_err", err, 0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("rel_acked", out_valid, 0);

      report(P_ALL,  4'b0000, 1'b0, "all_on");
      report(P_1001, 4'b1001, 1'b0, "p1001");
      report(P_0111, 4'b0111, 1'b0, "p0111");
      report(P_BAD,  4'b0000, 1'b1, "nomatch");
`ifdef SEG_READER_ERRCNT_EN
      check("err_cnt", err_cnt, 1);
`endif

      // Short glitch back to the last reported pattern: no new report
      report(P_0001, 4'b0001, 1'b0, "p0001");
      seg = P_ALL;
      tick();
      tick();
      seg = P_0001;
      saw = 1'b0;
      repeat (15) begin
         tick();
         if (out_valid) saw = 1'b1;
      end
      check("glitch_noreport", saw, 0);

      // Overrun: pending 0001 with ack low, new pattern 1001 settles
      report(P_0111, 4'b0111, 1'b0, "pre_ovr");
      seg = P_0001;
      n = 0;
      while (n < 20 && !out_valid) begin
         tick();
         n++;
      end
      check("ovr_pend_lat", n, 6);
      seg = P_1001;
      pulses = 0;
      repeat (12) begin
         tick();
         if (overrun) pulses++;
      end
      check("ovr_pulses", pulses, 1);
      check("ovr_valid", out_valid, 1);
      check("ovr_keep_code", code, 4'b0001);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ovr_ack_valid", out_valid, 0);
      tick();
      check("ovr_next_valid", out_valid, 1);
      check("ovr_next_code", code, 4'b1001);

      // Ack on the same edge the new pattern qualifies: no overrun
      seg = P_0111;
      pulses = 0;
      repeat (5) begin
         tick();
         if (overrun) pulses++;
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      if (overrun) pulses++;
      check("same_edge_ovr", pulses, 0);
      check("same_edge_valid0", out_valid, 0);
      tick();
      check("same_edge_valid1", out_valid, 1);
      check("same_edge_code", code, 4'b0111);
      ack = 1'b1;
      tick();
      ack = 1'b0;

      // Reset during SETTLE, then the held pattern is reported again
      seg = P_1001;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_code", code, 0);
      check("midrst_err", err, 0);
      check("midrst_ovr", overrun, 0);
      tick();
      rst = 1'b0;
      n = 0;
      while (n < 20 && !out_valid) begin
         tick();
         n++;
      end
      check("postrst_lat", n, 6);
      check("postrst_code", code, 4'b1001);
      check("postrst_err", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
